// File: rtl/mbinit_valtrain_seq.sv
// MBINIT valid-lane training sequencer: init/pattern/result/done handshake with
// the partner over sideband, N pattern bursts per attempt, bounded result
// retries, a response/pattern timeout and a sticky error state.
// Handshake: a TX request (o_ValidOutDatat_Module with o_TX_SbMessage) is held
// for the whole request state and is considered accepted on the cycle where
// i_falling_edge_busy pulses while i_Busy_SideBand is low; a received code is
// consumed only on a cycle where i_msg_valid is high.
module mbinit_valtrain_seq #(
   parameter int              MSG_W          = 4,
   parameter int              TO_W           = 16,
   parameter logic [TO_W-1:0] TIMEOUT_CYCLES = 16'd1000,
   parameter int              MAX_RETRY      = 2,
   parameter int              ITER_W         = 4
) (
   input  logic              CLK,
   input  logic              rst_n,
   input  logic              i_enable,
   input  logic [ITER_W-1:0] i_pattern_iters,
   input  logic [MSG_W-1:0]  i_Rx_SbMessage,
   input  logic              i_msg_valid,
   input  logic              i_Busy_SideBand,
   input  logic              i_falling_edge_busy,
   input  logic              i_VAL_Pattern_done,
   input  logic              i_VAL_Result_logged,
   output logic [MSG_W-1:0]  o_TX_SbMessage,
   output logic              o_ValidOutDatat_Module,
   output logic              o_Pattern_En,
   output logic              o_Module_end,
   output logic              o_train_error_req,
   output logic [2:0]        o_retry_count,
   output logic [3:0]        dbg_state
);

   typedef enum logic [3:0] {
      S_IDLE, S_INIT_REQ, S_WAIT_RESP, S_PATTERN, S_BUSY_RES, S_RESULT_REQ,
      S_CHECK_RESULT, S_BUSY_INIT, S_BUSY_DONE, S_DONE_REQ, S_DONE, S_ERROR
   } state_t;

   localparam logic [MSG_W-1:0] C_INIT_REQ    = MSG_W'(1);
   localparam logic [MSG_W-1:0] C_INIT_RESP   = MSG_W'(2);
   localparam logic [MSG_W-1:0] C_RESULT_REQ  = MSG_W'(3);
   localparam logic [MSG_W-1:0] C_RESULT_RESP = MSG_W'(4);
   localparam logic [MSG_W-1:0] C_DONE_REQ    = MSG_W'(5);
   localparam logic [MSG_W-1:0] C_DONE_RESP   = MSG_W'(6);
   localparam logic [2:0]       MAX_R         = 3'(MAX_RETRY);

   state_t            state, state_nxt;
   logic [MSG_W-1:0]  exp_code;
   logic [TO_W-1:0]   to_cnt;
   logic [ITER_W-1:0] iter_cnt, iter_tgt;
   logic [ITER_W:0]   iter_inc;
   logic [2:0]        retry_cnt;
   logic              timeout, resp_ok, iter_last, req_acked;

   assign timeout   = (to_cnt == TIMEOUT_CYCLES - TO_W'(1));
   assign resp_ok   = i_msg_valid && (i_Rx_SbMessage == exp_code);
   assign iter_inc  = {1'b0, iter_cnt} + (ITER_W+1)'(1);
   assign iter_last = (iter_inc == {1'b0, iter_tgt});
   assign req_acked = i_falling_edge_busy && !i_Busy_SideBand;

   assign o_retry_count = retry_cnt;
   assign dbg_state     = state;

   // State register
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic; enable low overrides every other transition
   always_comb begin
      state_nxt = state;
      if (!i_enable) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE:       if (!i_Busy_SideBand) state_nxt = S_INIT_REQ;
            S_INIT_REQ,
            S_RESULT_REQ,
            S_DONE_REQ:   if (req_acked) state_nxt = S_WAIT_RESP;
            S_WAIT_RESP: begin
               // a matching response beats a timeout in the same cycle
               if (resp_ok) begin
                  if (i_Rx_SbMessage == C_INIT_RESP)        state_nxt = S_PATTERN;
                  else if (i_Rx_SbMessage == C_RESULT_RESP) state_nxt = S_CHECK_RESULT;
                  else if (i_Rx_SbMessage == C_DONE_RESP)   state_nxt = S_DONE;
               end else if (timeout) begin
                  state_nxt = S_ERROR;
               end
            end
            S_PATTERN: begin
               // the final burst-done pulse beats a timeout in the same cycle
               if (i_VAL_Pattern_done && iter_last) state_nxt = S_BUSY_RES;
               else if (timeout)                    state_nxt = S_ERROR;
            end
            S_BUSY_RES:   if (!i_Busy_SideBand) state_nxt = S_RESULT_REQ;
            S_CHECK_RESULT: begin
               if (i_VAL_Result_logged)    state_nxt = S_BUSY_DONE;
               else if (retry_cnt < MAX_R) state_nxt = S_BUSY_INIT;
               else                        state_nxt = S_ERROR;
            end
            S_BUSY_INIT:  if (!i_Busy_SideBand) state_nxt = S_INIT_REQ;
            S_BUSY_DONE:  if (!i_Busy_SideBand) state_nxt = S_DONE_REQ;
            S_DONE:       state_nxt = S_DONE;
            S_ERROR:      state_nxt = S_ERROR;
            default:      state_nxt = S_IDLE;
         endcase
      end
   end

   // Counters, iteration target and expected response code
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt    <= '0;
         iter_cnt  <= '0;
         iter_tgt  <= ITER_W'(1);
         retry_cnt <= '0;
         exp_code  <= '0;
      end else begin
         if (state == S_IDLE)
            iter_tgt <= (i_pattern_iters == '0) ? ITER_W'(1) : i_pattern_iters;

         // saturating so a long stall can never wrap back below the limit
         if (state_nxt != state)
            to_cnt <= '0;
         else if ((state == S_WAIT_RESP || state == S_PATTERN) && to_cnt != '1)
            to_cnt <= to_cnt + TO_W'(1);

         if (state == S_IDLE || state_nxt == S_IDLE)
            iter_cnt <= '0;
         else if (state == S_PATTERN && i_VAL_Pattern_done)
            iter_cnt <= iter_last ? '0 : iter_inc[ITER_W-1:0];

         if (state == S_IDLE || state_nxt == S_IDLE)
            retry_cnt <= '0;
         else if (state == S_CHECK_RESULT && i_enable && !i_VAL_Result_logged && retry_cnt < MAX_R)
            retry_cnt <= retry_cnt + 3'd1;

         case (state_nxt)
            S_INIT_REQ:   exp_code <= C_INIT_RESP;
            S_RESULT_REQ: exp_code <= C_RESULT_RESP;
            S_DONE_REQ:   exp_code <= C_DONE_RESP;
            default:      exp_code <= exp_code;
         endcase
      end
   end

   // Registered outputs decoded from the next state
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         o_TX_SbMessage         <= '0;
         o_ValidOutDatat_Module <= 1'b0;
         o_Pattern_En           <= 1'b0;
         o_Module_end           <= 1'b0;
         o_train_error_req      <= 1'b0;
      end else begin
         case (state_nxt)
            S_INIT_REQ:   o_TX_SbMessage <= C_INIT_REQ;
            S_RESULT_REQ: o_TX_SbMessage <= C_RESULT_REQ;
            S_DONE_REQ:   o_TX_SbMessage <= C_DONE_REQ;
            default:      o_TX_SbMessage <= '0;
         endcase
         o_ValidOutDatat_Module <= (state_nxt == S_INIT_REQ) || (state_nxt == S_RESULT_REQ) ||
                                   (state_nxt == S_DONE_REQ);
         o_Pattern_En           <= (state_nxt == S_PATTERN);
         o_Module_end           <= (state_nxt == S_DONE);
         o_train_error_req      <= (state_nxt == S_ERROR);
      end
   end

endmodule

// File: tb/tb_mbinit_valtrain_seq.sv
// Directed bench for mbinit_valtrain_seq: nominal run, retries, retry
// exhaustion, response/pattern timeouts, ignored wrong code, reset and abort.
module tb_mbinit_valtrain_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic [3:0] iters;
   logic [3:0] rx_msg;
   logic       msg_valid, busy, fe_busy, pat_done, logged;
   logic [3:0] tx_msg;
   logic       tx_valid, pat_en, mod_end, err;
   logic [2:0] retry;
   logic [3:0] dbg;

   int total = 0;
   int bad   = 0;
   int init_sent = 0;

   mbinit_valtrain_seq #(
      .MSG_W(4), .TO_W(16), .TIMEOUT_CYCLES(16'd8), .MAX_RETRY(2), .ITER_W(4)
   ) dut (
      .CLK                    (clk),
      .rst_n                  (rst_n),
      .i_enable               (enable),
      .i_pattern_iters        (iters),
      .i_Rx_SbMessage         (rx_msg),
      .i_msg_valid            (msg_valid),
      .i_Busy_SideBand        (busy),
      .i_falling_edge_busy    (fe_busy),
      .i_VAL_Pattern_done     (pat_done),
      .i_VAL_Result_logged    (logged),
      .o_TX_SbMessage         (tx_msg),
      .o_ValidOutDatat_Module (tx_valid),
      .o_Pattern_En           (pat_en),
      .o_Module_end           (mod_end),
      .o_train_error_req      (err),
      .o_retry_count          (retry),
      .dbg_state              (dbg)
   );

   // clock
   always #5 clk = ~clk;

   // watchdog
   initial begin
      #500000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   task automatic check_outs(input string stage, input logic [3:0] e_tx, input logic e_valid,
                             input logic e_pat, input logic e_end, input logic e_err,
                             input logic [2:0] e_retry);
      check_eq({stage, ":tx_code"},    32'(tx_msg),   32'(e_tx));
      check_eq({stage, ":tx_valid"},   32'(tx_valid), 32'(e_valid));
      check_eq({stage, ":pattern_en"}, 32'(pat_en),   32'(e_pat));
      check_eq({stage, ":module_end"}, 32'(mod_end),  32'(e_end));
      check_eq({stage, ":train_err"},  32'(err),      32'(e_err));
      check_eq({stage, ":retry_cnt"},  32'(retry),    32'(e_retry));
   endtask

   // advance one edge; inputs change and outputs are sampled 1ns after it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // TX busy rises for a cycle, then drops with the falling-edge pulse
   task automatic handshake();
      busy = 1'b1;
      step();
      check_eq("req_hold_valid", 32'(tx_valid), 32'd1);
      busy    = 1'b0;
      fe_busy = 1'b1;
      step();
      fe_busy = 1'b0;
      check_eq("req_release_valid", 32'(tx_valid), 32'd0);
   endtask

   task automatic respond(input logic [3:0] code);
      rx_msg    = code;
      msg_valid = 1'b1;
      step();
      msg_valid = 1'b0;
      rx_msg    = '0;
   endtask

   task automatic pulse_done();
      pat_done = 1'b1;
      step();
      pat_done = 1'b0;
   endtask

   // one attempt starting just after entering INIT_REQ; ends one edge after
   // CHECK_RESULT has been evaluated with the given pass flag
   task automatic run_attempt(input logic pass, input int n_pat);
      check_eq("init_tx_code", 32'(tx_msg), 32'd1);
      if (tx_msg == 4'd1 && tx_valid) init_sent++;
      handshake();
      respond(4'd2);
      check_eq("pattern_start", 32'(pat_en), 32'd1);
      for (int i = 1; i < n_pat; i++) begin
         pulse_done();
         check_eq("pattern_hold", 32'(pat_en), 32'd1);
      end
      pulse_done();
      check_eq("pattern_end", 32'(pat_en), 32'd0);
      step();
      check_eq("result_tx_code", 32'(tx_msg), 32'd3);
      handshake();
      logged = pass;
      respond(4'd4);
      step();
      logged = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b0; iters = 4'd1; rx_msg = '0; msg_valid = 1'b0;
      busy = 1'b0; fe_busy = 1'b0; pat_done = 1'b0; logged = 1'b0;
      step(); step();
      check_outs("reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
      rst_n = 1'b1;
      step();

      // nominal: iters=2, all pass
      iters = 4'd2; enable = 1'b1;
      step();
      check_outs("nom_en_to_tx", 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
      run_attempt(1'b1, 2);
      check_eq("nom_busy_done_tx", 32'(tx_msg), 32'd0);
      step();
      check_outs("nom_done_req", 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
      handshake();
      respond(4'd6);
      check_outs("nom_done", 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
      repeat (3) step();
      check_outs("nom_done_hold", 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
      enable = 1'b0;
      step();
      check_outs("nom_abort", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

      // two failures then pass
      init_sent = 0; iters = 4'd1; enable = 1'b1;
      step();
      run_attempt(1'b0, 1);
      check_eq("retry_after_fail1", 32'(retry), 32'd1);
      step();
      run_attempt(1'b0, 1);
      check_eq("retry_after_fail2", 32'(retry), 32'd2);
      step();
      run_attempt(1'b1, 1);
      step();
      check_outs("retry_done_req", 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2);
      handshake();
      respond(4'd6);
      check_outs("retry_done", 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2);
      check_eq("retry_init_count", 32'(init_sent), 32'd3);
      enable = 1'b0;
      step();

      // three failures -> error
      enable = 1'b1;
      step();
      run_attempt(1'b0, 1);
      step();
      run_attempt(1'b0, 1);
      step();
      run_attempt(1'b0, 1);
      check_outs("err_set", 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2);
      repeat (4) step();
      check_eq("err_hold", 32'(err), 32'd1);
      enable = 1'b0;
      step();
      check_outs("err_cleared", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

      // busy blocks start in IDLE, then response timeout
      busy = 1'b1; enable = 1'b1;
      step();
      check_eq("idle_busy_hold", 32'(tx_valid), 32'd0);
      busy = 1'b0;
      step();
      check_eq("idle_start", 32'(tx_valid), 32'd1);
      handshake();
      repeat (7) step();
      check_eq("to_before", 32'(err), 32'd0);
      step();
      check_eq("to_fire", 32'(err), 32'd1);
      enable = 1'b0;
      step();

      // response in the 8th cycle wins, then pattern timeout
      enable = 1'b1;
      step();
      handshake();
      repeat (7) step();
      respond(4'd2);
      check_outs("to_resp_wins", 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
      repeat (7) step();
      check_eq("pat_to_before", 32'(err), 32'd0);
      step();
      check_outs("pat_to_fire", 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
      enable = 1'b0;
      step();

      // wrong code ignored, iters=0 acts as 1
      iters = 4'd0; enable = 1'b1;
      step();
      handshake();
      respond(4'd4);
      check_eq("wrong_code_ignored", 32'(pat_en), 32'd0);
      respond(4'd2);
      check_eq("right_code_pattern", 32'(pat_en), 32'd1);
      pulse_done();
      check_eq("iters0_one_burst", 32'(pat_en), 32'd0);
      step();
      check_eq("iters0_result_req", 32'(tx_msg), 32'd3);
      enable = 1'b0;
      step();

      // async reset in PATTERN, then abort in DONE_REQ
      iters = 4'd1; enable = 1'b1;
      step();
      handshake();
      respond(4'd2);
      check_eq("rst_pre_pattern", 32'(pat_en), 32'd1);
      rst_n = 1'b0;
      #1;
      check_outs("rst_async", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
      #1;
      rst_n = 1'b1;
      step();
      check_outs("rst_restart", 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
      run_attempt(1'b0, 1);
      step();
      run_attempt(1'b1, 1);
      step();
      check_outs("abort_done_req", 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1);
      enable = 1'b0;
      step();
      check_outs("abort_cleared", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
      enable = 1'b1;
      step();
      check_outs("abort_restart", 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
      enable = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mbinit_valtrain_seq.md
# mbinit_valtrain_seq

Parametrised MBINIT valid-lane training sequencer. It is the successor to the single-shot REPAIRVAL handshake and adds four things: a configurable number of pattern iterations, result-failure retries, a response/pattern timeout and a sticky error state. It sits between the MBINIT top-level controller and the sideband TX/RX wrappers. It drives the valid-pattern generator and reports done or train-error to the controller.

## Interface
Parameters:
- MSG_W, 4: sideband message code width.
- TO_W, 16: timeout counter width.
- TIMEOUT_CYCLES, 16'd1000: cycles allowed in WAIT_RESP or PATTERN before timeout; must be ≥2.
- MAX_RETRY, 2: result-failure retries before error; range 0..7.
- ITER_W, 4: width of the pattern-iteration request.

Ports:
- CLK  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_enable  in  1  controller enable; a low level aborts to IDLE from any state.
- i_pattern_iters  in  ITER_W  pattern bursts per attempt; 0 is treated as 1; sampled in IDLE.
- i_Rx_SbMessage  in  MSG_W  received sideband code.
- i_msg_valid  in  1  i_Rx_SbMessage is valid this cycle.
- i_Busy_SideBand  in  1  sideband TX busy.
- i_falling_edge_busy  in  1  one-cycle pulse when TX busy drops.
- i_VAL_Pattern_done  in  1  one-cycle pulse at the end of one pattern burst.
- i_VAL_Result_logged  in  1  partner result pass flag; sampled in CHECK_RESULT.
- o_TX_SbMessage  out  MSG_W  code to transmit; 0 when not sending.
- o_ValidOutDatat_Module  out  1  TX request valid.
- o_Pattern_En  out  1  pattern generator enable.
- o_Module_end  out  1  sequence complete; level output.
- o_train_error_req  out  1  training error; level output.
- o_retry_count  out  3  retries consumed in the current run.

## Operation
- Message codes:
  - init_req = 1, init_resp = 2
  - result_req = 3, result_resp = 4
  - done_req = 5, done_resp = 6
- Internal register `exp` holds the response code the block is waiting for.
- States and transitions. i_enable=0 forces IDLE from every state, and that check has priority over every other transition.
  - IDLE: latch max(i_pattern_iters,1) into `iter_tgt`. Clear retry count and iteration count. If i_enable & ~busy, go to INIT_REQ.
  - INIT_REQ: send code 1 and set exp=2. On falling_edge_busy & ~busy, go to WAIT_RESP.
  - WAIT_RESP:
    - i_msg_valid with code == exp → next state by code: 2 → PATTERN, 4 → CHECK_RESULT, 6 → DONE.
    - Any other valid code is ignored.
    - Timeout → ERROR.
  - PATTERN: o_Pattern_En=1.
    - Each i_VAL_Pattern_done increments the iteration count.
    - When the count reaches iter_tgt, clear the count and go to BUSY_RES.
    - Timeout → ERROR.
  - BUSY_RES: when ~busy, go to RESULT_REQ.
  - RESULT_REQ: send code 3 and set exp=4. On falling_edge_busy & ~busy, go to WAIT_RESP.
  - CHECK_RESULT (one cycle):
    - Pass (logged=1) → BUSY_DONE.
    - Fail with retry < MAX_RETRY → increment retry, go to BUSY_INIT.
    - Fail with retry == MAX_RETRY → ERROR.
  - BUSY_INIT: when ~busy, go to INIT_REQ.
  - BUSY_DONE: when ~busy, go to DONE_REQ.
  - DONE_REQ: send code 5 and set exp=6. On falling_edge_busy & ~busy, go to WAIT_RESP.
  - DONE: o_Module_end=1. Held until i_enable drops.
  - ERROR: o_train_error_req=1. Held until i_enable drops.
- Timeout counter:
  - Cleared on every state change.
  - Increments in WAIT_RESP and PATTERN.
  - Timeout fires when the count reaches TIMEOUT_CYCLES-1.
  - TO_W-bit unsigned; it must never wrap.
- A matching response and a timeout in the same cycle: the response wins.
- In PATTERN, the final i_VAL_Pattern_done and a timeout in the same cycle: the done pulse wins.
- The retry count saturates at MAX_RETRY. It is cleared only in IDLE.
- A result-failure retry does not reload iter_tgt.

## Timing
- Reset values:
  - o_TX_SbMessage=0, o_ValidOutDatat_Module=0, o_Pattern_En=0
  - o_Module_end=0, o_train_error_req=0, o_retry_count=0
  - State = IDLE; all counters = 0.
- All outputs are registered and decoded from the next state. Each output changes on the same edge on which the state register enters the state.
- o_ValidOutDatat_Module and o_TX_SbMessage stay high/valid for the whole INIT_REQ/RESULT_REQ/DONE_REQ residency.
- Minimum latencies:
  - Enable to first TX valid: 1 cycle.
  - Matching response to o_Pattern_En: 1 cycle.
  - Result pass to done_req: 2 cycles when busy is low.
- Reset mid-sequence returns to IDLE immediately, with all outputs 0.
- i_enable dropping clears all outputs on the next edge.

## Test plan
- Nominal run with iters=2 and the partner replying 2/4(pass)/6 → TX codes 1,3,5 in order. Pattern_En stays high until the 2nd done pulse. Module_end=1 and holds; retry_count=0.
- Result fails twice, then passes, with MAX_RETRY=2 → init_req is sent 3 times. retry_count=2, then Module_end=1.
- Result fails 3 times with MAX_RETRY=2 → ERROR; train_error_req=1 until i_enable=0. Every output is 0 one cycle after enable drops.
- TIMEOUT_CYCLES=8 with no response after init_req → train_error_req rises exactly 8 cycles after WAIT_RESP entry. A matching response on cycle 8 instead goes to PATTERN.
- Wrong code (4 while exp=2), then the correct code 2 → the wrong code is ignored and the block enters PATTERN. iters=0 finishes after one done pulse.
- rst_n asserted during PATTERN and i_enable toggled during DONE_REQ → immediate IDLE with all outputs 0. The sequence restarts cleanly with retry_count=0.
